// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants and FSM state type for the LFSR burst controller
package lfsr_pkg;

  localparam int                LFSR_W       = 11;
  localparam logic [LFSR_W-1:0] TAP_MASK_DEF = 11'h500;
  localparam logic [LFSR_W-1:0] SEED_RESET   = 11'h7FF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    PRESENT,
    DONE
  } state_t;

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - parameterised Fibonacci LFSR with parallel load and step enable
module lfsr_core #(
  parameter int           W     = 11,
  parameter logic [W-1:0] TAPS  = 11'h500,
  parameter logic [W-1:0] INIT  = '1
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] state,
  output logic         out_bit
);

  logic feedback;

  // Top stage is the serial output; feedback enters at stage 1.
  assign out_bit  = state[W-1];
  assign feedback = ^(state & TAPS);

  // Load has priority over step; otherwise the register holds.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= INIT;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= {state[W-2:0], feedback};
    end
  end

endmodule

// File: rtl/lfsr_burst_ctrl.sv
// rtl/lfsr_burst_ctrl.sv - burst sequencer packing LFSR keystream bits into handshaked words
module lfsr_burst_ctrl #(
  parameter int                LFSR_W   = lfsr_pkg::LFSR_W,
  parameter logic [LFSR_W-1:0] TAP_MASK = lfsr_pkg::TAP_MASK_DEF,
  parameter int                WORD_W   = 8,
  parameter int                LEN_W    = 16
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [LFSR_W-1:0] cfg_seed,
  input  logic              cfg_seed_we,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              seed_err,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LFSR_W-1:0] lfsr_state
);

  import lfsr_pkg::*;

  localparam int                CNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [LFSR_W-1:0] SEED_INIT = LFSR_W'(SEED_RESET);

  state_t              state, state_nxt;
  logic [LFSR_W-1:0]   seed_q;
  logic                seed_dirty;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    word_cnt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WORD_W-1:0]   sreg;
  logic [WORD_W:0]     sreg_shift;
  logic                seed_err_q;
  logic                seed_err_nxt;
  logic                lfsr_load;
  logic                lfsr_step;
  logic                lfsr_bit;
  logic                seed_we_idle;
  logic [LFSR_W-1:0]   seed_eff;
  logic                dirty_eff;
  logic                last_word;
  logic                start_take;

  // A seed written in the same IDLE cycle as start is the one that start uses.
  assign seed_we_idle = cfg_seed_we && (state == IDLE);
  assign seed_eff     = seed_we_idle ? cfg_seed : seed_q;
  assign dirty_eff    = seed_we_idle || seed_dirty;
  assign last_word    = (word_cnt == (len_q - LEN_W'(1)));
  assign start_take   = (state == IDLE) && start && !abort;
  assign sreg_shift   = {sreg, lfsr_bit};

  lfsr_core #(
    .W    (LFSR_W),
    .TAPS (TAP_MASK),
    .INIT (SEED_INIT)
  ) u_lfsr (
    .clock    (clock),
    .clear_n  (clear_n),
    .load     (lfsr_load),
    .load_val (seed_q),
    .step     (lfsr_step),
    .state    (lfsr_state),
    .out_bit  (lfsr_bit)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and LFSR control; abort overrides everything while busy.
  always_comb begin
    state_nxt    = state;
    seed_err_nxt = 1'b0;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;
    case (state)
      IDLE: begin
        if (start_take) begin
          if (seed_eff == '0) begin
            seed_err_nxt = 1'b1;
          end else if (burst_len == '0) begin
            state_nxt = DONE;
          end else if (dirty_eff) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end
      LOAD: begin
        lfsr_load = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        lfsr_step = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_nxt = last_word ? DONE : SHIFT;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = IDLE;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
    end
  end

  // Seed register, burst length, word/bit counters and the packing shift register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      seed_q     <= SEED_INIT;
      seed_dirty <= 1'b1;
      len_q      <= '0;
      word_cnt   <= '0;
      bit_cnt    <= '0;
      sreg       <= '0;
      seed_err_q <= 1'b0;
    end else begin
      seed_err_q <= seed_err_nxt;
      if (seed_we_idle) begin
        seed_q     <= cfg_seed;
        seed_dirty <= 1'b1;
      end else if (lfsr_load) begin
        seed_dirty <= 1'b0;
      end
      if (start_take) begin
        len_q <= burst_len;
      end
      bit_cnt <= lfsr_step ? (bit_cnt + CNT_W'(1)) : '0;
      if (lfsr_step) begin
        sreg <= sreg_shift[WORD_W-1:0];
      end
      if (state_nxt == IDLE) begin
        word_cnt <= '0;
      end else if ((state == PRESENT) && out_ready) begin
        word_cnt <= word_cnt + LEN_W'(1);
      end
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE) && !abort;
  assign seed_err  = seed_err_q;
  assign out_valid = (state == PRESENT);
  assign out_data  = out_valid ? sreg : '0;

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// tb/tb_lfsr_burst_ctrl.sv - directed self-checking bench for lfsr_burst_ctrl
module tb_lfsr_burst_ctrl;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic [10:0] cfg_seed = '0;
  logic        cfg_seed_we = 1'b0;
  logic        start = 1'b0;
  logic [15:0] burst_len = '0;
  logic        abort = 1'b0;
  logic        busy, done, seed_err;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [10:0] lfsr_state;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  lfsr_burst_ctrl dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .cfg_seed    (cfg_seed),
    .cfg_seed_we (cfg_seed_we),
    .start       (start),
    .burst_len   (burst_len),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .seed_err    (seed_err),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .lfsr_state  (lfsr_state)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic start_burst(input logic [15:0] len, input logic reseed, input logic [10:0] seed);
    cfg_seed    = seed;
    cfg_seed_we = reseed;
    burst_len   = len;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    cfg_seed_we = 1'b0;
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    tick();
    tests++; if ({busy, done, seed_err, out_valid} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, seed_err, out_valid}); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", out_data); end
    tests++; if (lfsr_state !== 11'h7FF) begin fails++; $display("FAIL reset_lfsr: got %h expected 7ff", lfsr_state); end
    clear_n = 1'b1;
    tick();
  endtask

  task automatic test_first_burst();
    int n;
    out_ready = 1'b1;
    start_burst(16'd3, 1'b0, 11'h000);
    wait_valid(n);
    tests++; if (n !== 9) begin fails++; $display("FAIL first_latency: got %0d expected 9", n); end
    tests++; if (out_data !== 8'hFF) begin fails++; $display("FAIL first_w0: got %h expected ff", out_data); end
    wait_valid(n);
    tests++; if (n !== 9 || out_data !== 8'hE0) begin fails++; $display("FAIL first_w1: got %h after %0d expected e0 after 9", out_data, n); end
    wait_valid(n);
    tests++; if (n !== 9 || out_data !== 8'h0C) begin fails++; $display("FAIL first_w2: got %h after %0d expected 0c after 9", out_data, n); end
    tick();
    tests++; if (done !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL first_done: got done=%b busy=%b expected 1 1", done, busy); end
    tick();
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL first_idle: got done=%b busy=%b expected 0 0", done, busy); end
    tests++; if (lfsr_state !== 11'h03C) begin fails++; $display("FAIL first_lfsr: got %h expected 03c", lfsr_state); end
  endtask

  task automatic test_continuation();
    int n;
    start_burst(16'd1, 1'b0, 11'h000);
    wait_valid(n);
    tests++; if (n !== 8 || out_data !== 8'h07) begin fails++; $display("FAIL cont_word: got %h after %0d expected 07 after 8", out_data, n); end
    tick();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL cont_done: got %b expected 1", done); end
    tick();
    tests++; if (lfsr_state !== 11'h419 || busy !== 1'b0) begin fails++; $display("FAIL cont_lfsr: got %h busy=%b expected 419 busy=0", lfsr_state, busy); end
  endtask

  task automatic test_backpressure();
    int n;
    logic stable;
    out_ready = 1'b0;
    start_burst(16'd3, 1'b1, 11'h7FF);
    wait_valid(n);
    tests++; if (n !== 9 || out_data !== 8'hFF) begin fails++; $display("FAIL bp_w0: got %h after %0d expected ff after 9", out_data, n); end
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (!(out_valid === 1'b1 && out_data === 8'hFF && lfsr_state === 11'h700)) stable = 1'b0;
    end
    tests++; if (stable !== 1'b1) begin fails++; $display("FAIL bp_hold: got data=%h lfsr=%h valid=%b expected ff 700 1", out_data, lfsr_state, out_valid); end
    out_ready = 1'b1;
    wait_valid(n);
    tests++; if (n !== 9 || out_data !== 8'hE0) begin fails++; $display("FAIL bp_w1: got %h after %0d expected e0 after 9", out_data, n); end
    wait_valid(n);
    tests++; if (n !== 9 || out_data !== 8'h0C) begin fails++; $display("FAIL bp_w2: got %h after %0d expected 0c after 9", out_data, n); end
    tick();
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_end: got busy=%b expected 0", busy); end
  endtask

  task automatic test_seed_err();
    int n;
    cfg_seed = 11'h000; cfg_seed_we = 1'b1;
    tick();
    cfg_seed_we = 1'b0;
    start_burst(16'd1, 1'b0, 11'h000);
    tests++; if ({seed_err, busy, out_valid} !== 3'b100) begin fails++; $display("FAIL seed_err_pulse: got %b expected 100", {seed_err, busy, out_valid}); end
    tick();
    tests++; if ({seed_err, busy, out_valid} !== 3'b000) begin fails++; $display("FAIL seed_err_clear: got %b expected 000", {seed_err, busy, out_valid}); end
    start_burst(16'd1, 1'b1, 11'h7FF);
    cfg_seed = 11'h000; cfg_seed_we = 1'b1;
    tick();
    cfg_seed_we = 1'b0;
    wait_valid(n);
    tests++; if (n !== 8 || out_data !== 8'hFF) begin fails++; $display("FAIL busy_we_word: got %h after %0d expected ff after 8", out_data, n); end
    tick();
    tick();
    start_burst(16'd1, 1'b0, 11'h000);
    tests++; if (seed_err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL busy_we_ignored: got seed_err=%b busy=%b expected 0 1", seed_err, busy); end
    wait_valid(n);
    tests++; if (n !== 8 || out_data !== 8'hE0) begin fails++; $display("FAIL busy_we_cont: got %h after %0d expected e0 after 8", out_data, n); end
    tick();
    tick();
  endtask

  task automatic test_abort();
    int n;
    start_burst(16'd3, 1'b1, 11'h7FF);
    wait_valid(n);
    tests++; if (out_data !== 8'hFF) begin fails++; $display("FAIL abort_w0: got %h expected ff", out_data); end
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tests++; if ({busy, out_valid, done} !== 3'b000) begin fails++; $display("FAIL abort_idle: got %b expected 000", {busy, out_valid, done}); end
    tests++; if (lfsr_state !== 11'h401) begin fails++; $display("FAIL abort_lfsr: got %h expected 401", lfsr_state); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_no_done: got %b expected 0", done); end
    start_burst(16'd1, 1'b0, 11'h000);
    wait_valid(n);
    tests++; if (n !== 8 || out_data !== 8'h80) begin fails++; $display("FAIL abort_resume: got %h after %0d expected 80 after 8", out_data, n); end
    tick();
    tick();
  endtask

  task automatic test_start_abort_same();
    start = 1'b1; abort = 1'b1; burst_len = 16'd2;
    tick();
    start = 1'b0; abort = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_abort_busy: got %b expected 0", busy); end
    tick();
    tests++; if ({busy, done, out_valid} !== 3'b000) begin fails++; $display("FAIL start_abort_after: got %b expected 000", {busy, done, out_valid}); end
  endtask

  task automatic test_zero_len();
    start_burst(16'd0, 1'b0, 11'h000);
    tests++; if ({done, busy, out_valid} !== 3'b110) begin fails++; $display("FAIL zero_len_done: got %b expected 110", {done, busy, out_valid}); end
    tick();
    tests++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL zero_len_idle: got %b expected 00", {done, busy}); end
  endtask

  task automatic test_period();
    int ndone;
    logic finished;
    ndone = 0;
    finished = 1'b0;
    out_ready = 1'b1;
    start_burst(16'd2047, 1'b1, 11'h7FF);
    for (int i = 0; i < 25000; i++) begin
      tick();
      if (done) ndone++;
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    tests++; if (finished !== 1'b1 || ndone !== 1) begin fails++; $display("FAIL period_done: got finished=%b pulses=%0d expected 1 1", finished, ndone); end
    tests++; if (lfsr_state !== 11'h7FF) begin fails++; $display("FAIL period_lfsr: got %h expected 7ff", lfsr_state); end
  endtask

  initial begin
    test_reset();
    test_first_burst();
    test_continuation();
    test_backpressure();
    test_seed_err();
    test_abort();
    test_start_abort_same();
    test_zero_len();
    test_period();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_burst_ctrl.md
Name: lfsr_burst_ctrl

Overview:
- Sequencer for the 11-bit Fibonacci LFSR keystream source (taps 11 and 9, output = stage 11).
- Owns seeding, start/abort and burst length; steps the LFSR only when a word is being built.
- Packs serial LFSR bits into WORD_W-bit words and delivers them to a downstream consumer over a valid/ready handshake.
- Sits between the register/config interface and any consumer of pseudo-random words (scrambler, BIST pattern source).

Parameters:
- LFSR_W, 11, LFSR length (stages 11..1).
- TAP_MASK, 11'h500, feedback taps, bit i = stage i+1 (stages 11 and 9).
- WORD_W, 8, output word width (>=1, <=16).
- LEN_W, 16, burst length counter width.

Ports:
- clock  in  1  single clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- cfg_seed  in  LFSR_W  seed value.
- cfg_seed_we  in  1  capture cfg_seed into seed register (ignored while busy).
- start  in  1  one-cycle request to run a burst (ignored while busy).
- burst_len  in  LEN_W  number of words in the burst, sampled on start.
- abort  in  1  terminate current burst.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on normal burst completion.
- seed_err  out  1  one-cycle pulse: start rejected because seed register = 0.
- out_data  out  WORD_W  packed word, MSB = first LFSR bit produced.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts word.
- lfsr_state  out  LFSR_W  current LFSR contents (debug/verification).

Behaviour:
- Reset (clear_n low, async): FSM=IDLE; seed register = 11'h7FF; LFSR = 11'h7FF; seed_dirty=1.
  - All outputs 0 except lfsr_state = 11'h7FF.
- LFSR step: out_bit = stage 11; shift stages up by one; stage 1 <= XOR of stages selected by TAP_MASK.
  - The LFSR steps only in SHIFT; it holds in every other state.
- cfg_seed_we in IDLE: seed register <= cfg_seed; seed_dirty <= 1. While busy: no effect.
- IDLE, on start:
  - If seed register == 0: pulse seed_err, stay IDLE.
  - Else if burst_len == 0: go to DONE.
  - Else: latch burst_len and go to LOAD if seed_dirty=1, otherwise straight to SHIFT, continuing the sequence.
- LOAD (1 cycle): LFSR <= seed register; seed_dirty <= 0; bit_cnt <= 0 -> SHIFT.
- SHIFT (WORD_W cycles): each cycle sreg <= {sreg[WORD_W-2:0], out_bit} and the LFSR steps. After the WORD_W-th shift -> PRESENT.
- PRESENT:
  - out_valid=1; out_data = sreg, held stable until accepted.
  - On out_valid && out_ready: word_cnt++; go to DONE if this was word burst_len, else to SHIFT.
  - Backpressure only freezes the FSM; no bits are lost.
- DONE: done=1 for one cycle -> IDLE; word_cnt cleared.
- Latency with seed_dirty=1: start sampled at edge 0, LOAD at edge 1, shifts on edges 2..WORD_W+1; out_valid high after edge WORD_W+1. With seed_dirty=0, one cycle less.
- Each further word appears WORD_W cycles after the previous handshake.
- abort (any busy state, priority over all else): FSM -> IDLE next edge; out_valid drops; no done.
  - LFSR keeps its current state; a partially built word is discarded.
- start and abort in the same IDLE cycle: abort wins and start is ignored.
- cfg_seed_we and start in the same IDLE cycle: the new seed is captured and used by that start, so the burst goes through LOAD.
- The LFSR never holds 0: seed 0 is rejected and the all-zero state is unreachable.

Decomposition:
- Package lfsr_pkg: LFSR_W, default TAP_MASK, reset seed 11'h7FF, FSM state enum {IDLE, LOAD, SHIFT, PRESENT, DONE}.
- Sub-module lfsr_core: parameterised Fibonacci LFSR with load, load_val, step, state and out_bit ports.
- The controller instantiates one lfsr_core.

Test Plan:
- Reset, start with burst_len=3, out_ready=1 -> words 0xFF, 0xE0, 0x0C. First out_valid 9 cycles after the start edge; done pulses once; busy then drops.
- Continuation: after the first test, start burst_len=1 with no cfg_seed_we -> no LOAD; word 0x07; first out_valid 8 cycles after start.
- Backpressure: hold out_ready=0 for 20 cycles during the first word -> out_data stays 0xFF, lfsr_state unchanged; sequence then proceeds 0xE0, 0x0C.
- cfg_seed=0, start -> seed_err pulse, busy stays 0, out_valid stays 0. cfg_seed_we while busy -> seed register unchanged.
- Abort mid-SHIFT of word 2 -> IDLE next cycle, no done, no out_valid. Next start without a reseed continues from the held LFSR state.
- Period check: seed 11'h7FF, burst_len=2047, out_ready=1 -> done pulses; lfsr_state == 11'h7FF (16376 steps = 8 x 2047).
